// File: rtl/streaming_best_gain_selector.sv
// Keeps the highest-gain candidate of each batch (earliest wins ties unless STREAMING_BEST_GAIN_RANDOM_TIE_EN selects an LFSR coin flip).
// Result valid 1 cycle after the last beat; out_ready stays low while a result is held until in_result_ready.
module streaming_best_gain_selector #(
  parameter int          MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
  parameter int          MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
  parameter int          MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int          MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int          MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX        = 2,
  parameter logic [15:0] LFSR_SEED                                   = 16'hACE1
) (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_valid,
  output logic out_ready,
  input  logic in_last,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_gain,
  input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] in_integer_assignment,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] in_boolean_assignment,
  output logic out_valid,
  input  logic in_result_ready,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_best_gain,
  output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] out_best_integer_assignment,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_best_boolean_assignment,
  output logic [MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX-1:0] out_best_index,
  output logic out_overflow
);
  localparam int GW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1;
  localparam int IW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE * (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX);
  localparam int BW = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX;
  localparam logic [CW-1:0] LAST_POS = '1;

  // A zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 16'h0) begin : g_seed_check
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] best_gain_q, best_gain_d;
  logic [IW-1:0] best_int_q, best_int_d;
  logic [BW-1:0] best_bool_q, best_bool_d;
  logic [CW-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0] pos_q, pos_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic          beat_last;
  logic          take;
  logic          tie_win;
  logic [CW-1:0] cur_pos;

`ifdef STREAMING_BEST_GAIN_RANDOM_TIE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) lfsr_q <= LFSR_SEED;
    else           lfsr_q <= lfsr_d;
  end

  assign tie_win = lfsr_q[0];
`else
  assign tie_win = 1'b0;
`endif

  assign out_ready = (state_q != HOLD);
  assign accept    = in_valid && out_ready;
  // The first beat of a batch always sits at position 0, whatever pos_q holds.
  assign cur_pos   = (state_q == IDLE) ? '0 : pos_q;
  assign beat_last = in_last || (cur_pos == LAST_POS);
  assign take      = (state_q == IDLE) || (in_gain > best_gain_q) ||
                     ((in_gain == best_gain_q) && tie_win);

  always_comb begin
    state_d     = state_q;
    best_gain_d = best_gain_q;
    best_int_d  = best_int_q;
    best_bool_d = best_bool_q;
    best_idx_d  = best_idx_q;
    pos_d       = pos_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (take) begin
            best_gain_d = in_gain;
            best_int_d  = in_integer_assignment;
            best_bool_d = in_boolean_assignment;
            best_idx_d  = cur_pos;
          end
          pos_d = cur_pos + 1'b1;
          if (beat_last) begin
            state_d    = HOLD;
            overflow_d = !in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (in_result_ready) begin
          state_d = IDLE;
          pos_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= IDLE;
      best_gain_q <= '0;
      best_int_q  <= '0;
      best_bool_q <= '0;
      best_idx_q  <= '0;
      pos_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_gain_q <= best_gain_d;
      best_int_q  <= best_int_d;
      best_bool_q <= best_bool_d;
      best_idx_q  <= best_idx_d;
      pos_q       <= pos_d;
      overflow_q  <= overflow_d;
    end
  end

  // The running best stays hidden until the batch is closed.
  assign out_valid                   = (state_q == HOLD);
  assign out_best_gain               = out_valid ? best_gain_q : '0;
  assign out_best_integer_assignment = out_valid ? best_int_q  : '0;
  assign out_best_boolean_assignment = out_valid ? best_bool_q : '0;
  assign out_best_index              = out_valid ? best_idx_q  : '0;
  assign out_overflow                = out_valid & overflow_q;
endmodule

// File: tb/tb_streaming_best_gain_selector.sv
// Bench for streaming_best_gain_selector: batch-level reference model checked every cycle plus directed literal checks.
module tb_streaming_best_gain_selector;
  localparam int GW    = 3;
  localparam int IW    = 8;
  localparam int BW    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
`ifdef STREAMING_BEST_GAIN_RANDOM_TIE_EN
  localparam bit RANDOM_TIE = 1'b1;
`else
  localparam bit RANDOM_TIE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, in_result_ready;
  logic [GW-1:0] in_gain;
  logic [IW-1:0] in_int;
  logic [BW-1:0] in_bool;
  logic          out_ready, out_valid, out_overflow;
  logic [GW-1:0] out_gain;
  logic [IW-1:0] out_int;
  logic [BW-1:0] out_bool;
  logic [CW-1:0] out_idx;

  always #5 clk = ~clk;

  streaming_best_gain_selector dut (
    .in_clk                      (clk),
    .in_reset                    (rst_n),
    .in_valid                    (in_valid),
    .out_ready                   (out_ready),
    .in_last                     (in_last),
    .in_gain                     (in_gain),
    .in_integer_assignment       (in_int),
    .in_boolean_assignment       (in_bool),
    .out_valid                   (out_valid),
    .in_result_ready             (in_result_ready),
    .out_best_gain               (out_gain),
    .out_best_integer_assignment (out_int),
    .out_best_boolean_assignment (out_bool),
    .out_best_index              (out_idx),
    .out_overflow                (out_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: collect the accepted beats of a batch, pick the winner when the batch closes.
  typedef struct {
    logic [GW-1:0] g;
    logic [IW-1:0] iv;
    logic [BW-1:0] bv;
    bit            tie;
  } beat_t;

  beat_t         batch[$];
  bit            m_hold;
  logic [GW-1:0] m_gain;
  logic [IW-1:0] m_int;
  logic [BW-1:0] m_bool;
  int            m_idx;
  bit            m_ovf;
  logic [15:0]   m_lfsr;
  int            m_w;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      batch.delete();
      m_hold = 1'b0;
      m_lfsr = 16'hACE1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_gain", 32'(out_gain), 32'd0);
    end else begin
      check("cyc_valid", 32'(out_valid), 32'(m_hold));
      check("cyc_ready", 32'(out_ready), 32'(!m_hold));
      if (m_hold) begin
        check("cyc_gain", 32'(out_gain), 32'(m_gain));
        check("cyc_index", 32'(out_idx), 32'(m_idx));
        check("cyc_int", 32'(out_int), 32'(m_int));
        check("cyc_bool", 32'(out_bool), 32'(m_bool));
        check("cyc_overflow", 32'(out_overflow), 32'(m_ovf));
        if (in_result_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        batch.push_back('{in_gain, in_int, in_bool, m_lfsr[0]});
        m_lfsr = lfsr_next(m_lfsr);
        if (in_last || batch.size() == DEPTH) begin
          m_w = 0;
          for (int i = 1; i < batch.size(); i++) begin
            if (batch[i].g > batch[m_w].g ||
                (RANDOM_TIE && batch[i].g == batch[m_w].g && batch[i].tie)) m_w = i;
          end
          m_gain = batch[m_w].g;
          m_int  = batch[m_w].iv;
          m_bool = batch[m_w].bv;
          m_idx  = m_w;
          m_ovf  = !in_last;
          m_hold = 1'b1;
          batch.delete();
        end
      end
    end
  end

  int beat_no = 0;

  task automatic send(input int g, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    in_gain  = GW'(g);
    in_int   = IW'(beat_no * 37 + 11);
    in_bool  = BW'(beat_no);
    beat_no++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input int g, input int idx, input bit ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd0);
    check({name, "_gain"}, 32'(out_gain), 32'(g));
    check({name, "_index"}, 32'(out_idx), 32'(idx));
    check({name, "_overflow"}, 32'(out_overflow), 32'(ovf));
  endtask

  task automatic release_result();
    in_result_ready = 1'b1;
    @(posedge clk); #1;
    in_result_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_result_ready = 1'b0;
    in_gain = '0; in_int = '0; in_bool = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(out_ready), 32'd1);
    check("reset_overflow", 32'(out_overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal gains straight after reset: earliest wins, or the seeded LFSR decides (all coin flips are 1).
    send(6, 0); send(6, 0); send(6, 0); send(6, 1);
    expect_result("tie", 6, RANDOM_TIE ? 3 : 0, 1'b0);
    release_result();

    send(3, 0); send(5, 0); send(2, 0); send(5, 1);
    expect_result("basic", 5, 1, 1'b0);
    release_result();

    send(0, 1);
    expect_result("single", 0, 0, 1'b0);
    check("single_ready_low", 32'(out_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("single_ready_held", 32'(out_ready), 32'd0);
    release_result();
    check("single_released_valid", 32'(out_valid), 32'd0);
    check("single_released_ready", 32'(out_ready), 32'd1);

    send(1, 0); send(2, 0); send(3, 0); send(7, 0);
    expect_result("ovf_last", 7, 3, 1'b1);
    release_result();
    send(7, 0); send(2, 0); send(3, 0); send(1, 0);
    expect_result("ovf_first", 7, 0, 1'b1);
    release_result();
    send(2, 0); send(6, 0); send(1, 1);
    expect_result("short", 6, 1, 1'b0);
    release_result();

    // Held result with a beat waiting: nothing is taken until the cycle after release.
    send(2, 0); send(6, 1);
    in_valid = 1'b1; in_last = 1'b1; in_gain = 3'd7; in_int = 8'h5A; in_bool = 2'b10;
    repeat (5) @(posedge clk);
    #1;
    check("hold_gain", 32'(out_gain), 32'd6);
    check("hold_index", 32'(out_idx), 32'd1);
    check("hold_valid", 32'(out_valid), 32'd1);
    release_result();
    check("hold_idle_ready", 32'(out_ready), 32'd1);
    check("hold_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("next_valid", 32'(out_valid), 32'd1);
    check("next_gain", 32'(out_gain), 32'd7);
    check("next_index", 32'(out_idx), 32'd0);
    check("next_int", 32'(out_int), 32'h5A);
    release_result();

    // Reset while a result is held, then mid-batch.
    send(4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 32'(out_valid), 32'd0);
    check("arst_hold_gain", 32'(out_gain), 32'd0);
    check("arst_hold_ready", 32'(out_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(5, 0); send(6, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_valid", 32'(out_valid), 32'd0);
    check("arst_mid_index", 32'(out_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1, 0); send(4, 1);
    expect_result("post_reset", 4, 1, 1'b0);
    release_result();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
